// File: rtl/vga_color_sequencer_pkg.sv
// Shared definitions for the frame-synchronous colour sequencer and the VGA datapath.
package vga_color_sequencer_pkg;

    // Default palette geometry
    localparam int unsigned ChannelBits  = 4;
    localparam int unsigned ChannelCount = 4;
    localparam int unsigned PaletteDepth = 4;
    localparam int unsigned AddrBits     = 2;
    localparam int unsigned DwellBits    = 8;

    // Colour word as seen by vga_gpu.color
    localparam int unsigned ColorBits = ChannelCount * ChannelBits;

    typedef logic [ColorBits-1:0] palette_entry_t;

    // 640x480@60 timing, identical to the values handed to vga_gpu
    localparam int unsigned HVisible = 640;
    localparam int unsigned HFront   = 16;
    localparam int unsigned HSync    = 96;
    localparam int unsigned HBack    = 48;
    localparam int unsigned VVisible = 480;
    localparam int unsigned VFront   = 10;
    localparam int unsigned VSync    = 2;
    localparam int unsigned VBack    = 33;

    // Commit state: idle, or armed waiting for the next frame tick
    typedef enum logic [0:0] {
        StIdle,
        StArmed
    } seq_state_e;

    // Last dwell count value before advancing; a dwell of 0 behaves like 1
    function automatic int unsigned dwell_limit(input int unsigned dwell);
        return (dwell == 0) ? 0 : dwell - 1;
    endfunction

endpackage

// File: rtl/vga_color_sequencer_if.sv
// Shadow-palette write port and commit control of the colour sequencer.
interface vga_color_sequencer_if #(
    parameter int unsigned ADDR_BITS = 2,
    parameter int unsigned DATA_BITS = 16
);

    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 commit;
    logic                 commit_pending;

    // Host side: issues writes and commit pulses
    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output commit,
        input  wr_ready,
        input  commit_pending
    );

    // Sequencer side: accepts writes and reports commit status
    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output wr_ready,
        output commit_pending
    );

endinterface

// File: rtl/vga_color_sequencer_frame_tick.sv
// Rising-edge detector on v_sync; reusable by any frame-synchronous block.
module vga_frame_tick (
    input  logic clk,
    input  logic resetn,
    input  logic v_sync,
    output logic tick,
    output logic frame_tick
);

    logic vs_q;

    // Combinational tick: high in the first cycle v_sync is seen high
    assign tick = v_sync & ~vs_q;

    // Previous v_sync sample and the registered one-cycle frame pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vs_q       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_q       <= v_sync;
            frame_tick <= tick;
        end
    end

endmodule

// File: rtl/vga_color_sequencer.sv
// Double-buffered palette sequencer feeding vga_gpu.color. All visible changes happen on the
// frame tick so a frame never tears; commits copy the shadow palette at that same boundary.
module vga_color_sequencer
    import vga_color_sequencer_pkg::*;
#(
    parameter int unsigned CHANNEL_BITS  = 4,
    parameter int unsigned CHANNEL_COUNT = 4,
    parameter int unsigned PALETTE_DEPTH = 4,
    parameter int unsigned ADDR_BITS     = 2,
    parameter int unsigned DWELL_BITS    = 8
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  v_sync,
    input  logic                                  enable,
    input  logic [DWELL_BITS-1:0]                 dwell,
    input  logic [ADDR_BITS-1:0]                  last_idx,
    vga_color_sequencer_if.slave                  host,
    output logic [CHANNEL_COUNT*CHANNEL_BITS-1:0] color,
    output logic [ADDR_BITS-1:0]                  index,
    output logic                                  frame_tick
);

    localparam int unsigned ColorW = CHANNEL_COUNT * CHANNEL_BITS;

    logic                  tick;
    logic                  wr_fire;
    logic                  apply;
    seq_state_e            state_q;
    logic [ColorW-1:0]     shadow_q [PALETTE_DEPTH];
    logic [ColorW-1:0]     active_q [PALETTE_DEPTH];
    logic [ADDR_BITS-1:0]  index_q;
    logic [ADDR_BITS-1:0]  index_d;
    logic [DWELL_BITS-1:0] dwell_cnt_q;
    logic [DWELL_BITS-1:0] dwell_cnt_d;
    logic [ColorW-1:0]     color_q;

    vga_frame_tick u_frame_tick (
        .clk        (clk),
        .resetn     (resetn),
        .v_sync     (v_sync),
        .tick       (tick),
        .frame_tick (frame_tick)
    );

    // Writes are refused while a commit is armed so the committed snapshot stays intact
    assign host.wr_ready       = (state_q == StIdle);
    assign host.commit_pending = (state_q == StArmed);
    assign wr_fire             = host.wr_valid & host.wr_ready;
    assign apply               = tick & (state_q == StArmed);

    // Commit FSM: a commit arms, the next frame tick applies and disarms
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (host.commit) state_q <= StArmed;
                StArmed: if (tick)        state_q <= StIdle;
                default:                  state_q <= StIdle;
            endcase
        end
    end

    // Shadow palette: accepts handshaken writes; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < PALETTE_DEPTH; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wr_fire && (32'(host.wr_addr) < PALETTE_DEPTH)) begin
            shadow_q[host.wr_addr] <= host.wr_data;
        end
    end

    // Active palette: whole-palette copy from the shadow at the applying tick
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < PALETTE_DEPTH; i++) begin
                active_q[i] <= '0;
            end
        end else if (apply) begin
            for (int i = 0; i < PALETTE_DEPTH; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // Next index and dwell count, used only on a tick; >= keeps a shrunk dwell from wrapping
    always_comb begin
        index_d     = index_q;
        dwell_cnt_d = dwell_cnt_q;
        if (enable) begin
            if (32'(dwell_cnt_q) >= dwell_limit(32'(dwell))) begin
                dwell_cnt_d = '0;
                index_d     = (index_q >= last_idx) ? '0 : index_q + 1'b1;
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
        end
    end

    // Sequencer state and colour; colour reads the post-commit palette at the new index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_q     <= '0;
            dwell_cnt_q <= '0;
            color_q     <= '0;
        end else if (tick) begin
            index_q     <= index_d;
            dwell_cnt_q <= dwell_cnt_d;
            color_q     <= apply ? shadow_q[index_d] : active_q[index_d];
        end
    end

    assign color = color_q;
    assign index = index_q;

endmodule
